// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// prefix_adder_pipe : pipelined Sklansky parallel-prefix adder/subtractor
// Rev 1.0
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH          = 32,
  parameter int LEVELS_PER_STG = 2,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int STAGES = (LEVELS + LEVELS_PER_STG - 1) / LEVELS_PER_STG;
  localparam int NREGS  = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] praw;
    logic             c0;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Applies prefix levels lo..hi; each combining bit takes the top bit of the
  // lower half of its Sklansky block as partner.
  function automatic stage_t run_levels(input stage_t st, input int lo, input int hi);
    stage_t           res;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int               j;
    res = st;
    g   = st.g;
    p   = st.p;
    for (int k = 1; k <= LEVELS; k++) begin
      if (k >= lo && k <= hi) begin
        g = res.g;
        p = res.p;
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> (k - 1)) & 1) == 1) begin
            j = ((i >> (k - 1)) << (k - 1)) - 1;
            res.g[i] = g[i] | (p[i] & g[j]);
            res.p[i] = p[i] & p[j];
          end
        end
      end
    end
    return res;
  endfunction

  stage_t           head;
  stage_t           stg_in  [STAGES];
  stage_t           stg_out [STAGES];
  stage_t           pipe_q  [NREGS];
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] sum_n;
  logic             advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    b_eff = in_op[0] ? ~in_b : in_b;
    case (in_op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      default: c0 = in_cin;
    endcase
    head.valid = in_valid;
    head.p     = in_a ^ b_eff;
    head.praw  = in_a ^ b_eff;
    // carry-in folded into bit 0 so every prefix G is a true carry-out
    head.g     = in_a & b_eff;
    head.g[0]  = (in_a[0] & b_eff[0]) | ((in_a[0] ^ b_eff[0]) & c0);
    head.c0    = c0;
    head.tag   = in_tag;

    stg_in[0] = head;
    for (int s = 1; s < STAGES; s++) begin
      stg_in[s] = pipe_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      stg_out[s] = run_levels(stg_in[s], s * LEVELS_PER_STG + 1, (s + 1) * LEVELS_PER_STG);
    end

    sum_n = stg_out[STAGES-1].praw ^ {stg_out[STAGES-1].g[WIDTH-2:0], stg_out[STAGES-1].c0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NREGS; s++) begin
        pipe_q[s].valid <= 1'b0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      for (int s = 0; s < NREGS; s++) begin
        pipe_q[s] <= stg_out[s];
      end
      out_valid <= stg_out[STAGES-1].valid;
      out_sum   <= sum_n;
      out_cout  <= stg_out[STAGES-1].g[WIDTH-1];
      out_ovf   <= stg_out[STAGES-1].g[WIDTH-1] ^ stg_out[STAGES-1].g[WIDTH-2];
      out_zero  <= ~|sum_n;
      out_tag   <= stg_out[STAGES-1].tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// tb_prefix_adder_pipe : directed + random scoreboard bench for prefix_adder_pipe (W=32, 3 stages)
module tb_prefix_adder_pipe;

  localparam int W   = 32;
  localparam int LPS = 2;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic          in_cin;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  prefix_adder_pipe #(.WIDTH(W), .LEVELS_PER_STG(LPS), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  logic rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
  endtask

  function automatic exp_t mk(input logic [TW-1:0] tag, input logic [W-1:0] sum,
                              input logic cout, input logic ovf, input logic zero);
    exp_t e;
    e.tag = tag; e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin, input logic [TW-1:0] tag);
    exp_t       e;
    logic [W-1:0] bp;
    logic       c;
    logic [W:0] full;
    bp   = op[0] ? ~b : b;
    c    = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c};
    e.tag  = tag;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    e.zero = (full[W-1:0] == '0);
    return e;
  endfunction

  // Scoreboard consumer: every output transfer must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("out_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
        chk("out_sum", 64'(out_sum), 64'(mon_e.sum));
        chk("out_flags", 64'({out_cout, out_ovf, out_zero}), 64'({mon_e.cout, mon_e.ovf, mon_e.zero}));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the op.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic cin, input logic [TW-1:0] tag, input exp_t e, output int stalls);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
    else sb.push_back(e);
    stalls = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         cin;
    logic [TW-1:0] tg;
    logic [W-1:0] corner [5];

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_cin = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // wrap to zero, with latency of 3 cycles
    send(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 4'h1, mk(4'h1, 32'h0, 1'b1, 1'b0, 1'b1), st);
    @(negedge clk); chk("lat_c1_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_c2_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_c3_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // subtract and carry-in modes
    send(32'h8000_0000, 32'h1, 2'b01, 1'b0, 4'h2, mk(4'h2, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), st);
    send(32'h3,         32'h5, 2'b01, 1'b0, 4'h3, mk(4'h3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), st);
    send(32'h7FFF_FFFF, 32'h0, 2'b10, 1'b1, 4'h4, mk(4'h4, 32'h8000_0000, 1'b0, 1'b1, 1'b0), st);
    send(32'h5,         32'h5, 2'b11, 1'b0, 4'h5, mk(4'h5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0), st);
    send(32'h5,         32'h5, 2'b11, 1'b1, 4'h6, mk(4'h6, 32'h0, 1'b1, 1'b0, 1'b1), st);
    send(32'h1234_5678, 32'h0, 2'b10, 1'b0, 4'h7, mk(4'h7, 32'h1234_5678, 1'b0, 1'b0, 1'b0), st);
    drain();

    // full-throughput stream, tags 0..7
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; op = 2'(i % 4); cin = 1'(i / 4);
      send(a, b, op, cin, 4'(i), model(a, b, op, cin, 4'(i)), st);
      chk("stream_no_stall", 64'(st), 64'd0);
    end
    drain();

    // backpressure with a full pipe
    out_ready = 1'b0;
    for (int i = 8; i < 11; i++) begin
      a = $urandom; b = $urandom;
      send(a, b, 2'b00, 1'b0, 4'(i), model(a, b, 2'b00, 1'b0, 4'(i)), st);
    end
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_frozen_tag", 64'(out_tag), 64'(sb[0].tag));
      chk("bp_frozen_sum", 64'(out_sum), 64'(sb[0].sum));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // reset with three ops in flight: none may emerge
    for (int i = 1; i < 4; i++) begin
      a = $urandom; b = $urandom;
      send(a, b, 2'b01, 1'b0, 4'(i), model(a, b, 2'b01, 1'b0, 4'(i)), st);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    send(32'h10, 32'h20, 2'b00, 1'b0, 4'hC, mk(4'hC, 32'h30, 1'b0, 1'b0, 1'b0), st);
    drain();

    // random traffic with random backpressure and input gaps
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      op  = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      tg  = 4'($urandom_range(0, 15));
      send(a, b, op, cin, tg, model(a, b, op, cin, tg), st);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
